// File: rtl/signed_frame_accumulator.sv
// Signed frame accumulator: sums FRAME_LEN signed samples (add or subtract) and emits one result per frame.
// Define SIGNED_ACC_SATURATE_EN to clamp overflowing sums instead of wrapping modulo 2^ACC_W.
module signed_frame_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Sub,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [ACC_W-1:0]  Out_Data,
  output logic              Out_Overflow,
  output logic              Out_Valid,
  input  logic              Out_Ready
);

  // Two guard bits: sign extension to ACC_W+1 plus headroom for the addition carry.
  localparam int SUM_W = ACC_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                   state_r, state_s;
  logic signed [ACC_W-1:0]  acc_r, acc_s;
  logic [7:0]               cnt_r, cnt_s;
  logic                     ovf_r, ovf_s;
  logic [ACC_W-1:0]         out_data_r, out_data_s;
  logic                     out_ovf_r, out_ovf_s;
  logic                     out_valid_r, out_valid_s;

  logic signed [SUM_W-1:0]  ext_s, opnd_s, sum_s;
  logic                     add_ovf_s;
  logic signed [ACC_W-1:0]  new_acc_s;
  logic                     accept_s;
  logic                     last_s;

  assign accept_s = In_Valid && (state_r != EMIT);
  assign last_s   = (cnt_r == 8'(FRAME_LEN - 1));

  // Extended add/subtract datapath with signed-range overflow detection.
  always_comb begin
    ext_s     = SUM_W'($signed(In_Data));
    opnd_s    = In_Sub ? -ext_s : ext_s;
    sum_s     = SUM_W'(acc_r) + opnd_s;
    // In range only when the bits from the ACC_W sign bit upward are all equal.
    add_ovf_s = !((&sum_s[SUM_W-1:ACC_W-1]) || !(|sum_s[SUM_W-1:ACC_W-1]));
`ifdef SIGNED_ACC_SATURATE_EN
    if (add_ovf_s) begin
      new_acc_s = sum_s[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      new_acc_s = sum_s[ACC_W-1:0];
    end
`else
    new_acc_s = sum_s[ACC_W-1:0];
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    ovf_s       = ovf_r;
    out_data_s  = out_data_r;
    out_ovf_s   = out_ovf_r;
    out_valid_s = out_valid_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (accept_s) begin
          acc_s = new_acc_s;
          ovf_s = ovf_r | add_ovf_s;
          if (last_s) begin
            state_s     = EMIT;
            cnt_s       = 8'd0;
            out_data_s  = new_acc_s;
            out_ovf_s   = ovf_r | add_ovf_s;
            out_valid_s = 1'b1;
          end else begin
            state_s = ACCUM;
            cnt_s   = cnt_r + 8'd1;
          end
        end else begin
          state_s = state_r;
        end
      end
      EMIT: begin
        if (Out_Ready) begin
          state_s     = IDLE;
          acc_s       = '0;
          cnt_s       = 8'd0;
          ovf_s       = 1'b0;
          out_data_s  = '0;
          out_ovf_s   = 1'b0;
          out_valid_s = 1'b0;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s     = IDLE;
        acc_s       = '0;
        cnt_s       = 8'd0;
        ovf_s       = 1'b0;
        out_data_s  = '0;
        out_ovf_s   = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= 8'd0;
      ovf_r       <= 1'b0;
      out_data_r  <= '0;
      out_ovf_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      ovf_r       <= ovf_s;
      out_data_r  <= out_data_s;
      out_ovf_r   <= out_ovf_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign In_Ready     = (state_r != EMIT);
  assign Out_Data     = out_data_r;
  assign Out_Overflow = out_ovf_r;
  assign Out_Valid    = out_valid_r;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Self-checking bench for signed_frame_accumulator: default, ACC_W=8 and FRAME_LEN=1 instances.
module tb_signed_frame_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic [7:0]  in_data;
  logic        in_sub, in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_ovf, out_valid, out_ready;

  signed_frame_accumulator dut (
    .clk(clk), .rst_n(rst_n), .In_Data(in_data), .In_Sub(in_sub), .In_Valid(in_valid),
    .In_Ready(in_ready), .Out_Data(out_data), .Out_Overflow(out_ovf), .Out_Valid(out_valid),
    .Out_Ready(out_ready)
  );

  // ACC_W = 8 instance
  logic [7:0] d8, o8;
  logic       s8, v8, r8, ovf8, ov8, ordy8;

  signed_frame_accumulator #(.DATA_W(8), .ACC_W(8), .FRAME_LEN(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .In_Data(d8), .In_Sub(s8), .In_Valid(v8),
    .In_Ready(r8), .Out_Data(o8), .Out_Overflow(ovf8), .Out_Valid(ov8), .Out_Ready(ordy8)
  );

  // FRAME_LEN = 1 instance
  logic [7:0]  d1;
  logic [15:0] o1;
  logic        s1, v1, r1, ovf1, ov1, ordy1;

  signed_frame_accumulator #(.DATA_W(8), .ACC_W(16), .FRAME_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .In_Data(d1), .In_Sub(s1), .In_Valid(v1),
    .In_Ready(r1), .Out_Data(o1), .Out_Overflow(ovf1), .Out_Valid(ov1), .Out_Ready(ordy1)
  );

  typedef struct {
    logic [31:0] d;    // sample i in d[8*i +: 8]
    logic [3:0]  s;    // bit i = subtract sample i
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // scoreboard monitor: results compared on handshake cycles, idle outputs must be zero
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (out_ready) begin
          if (sbq.size() == 0) begin
            check("sb_unexpected_result", 32'(out_data), 32'hDEAD);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("sb_data", 32'(out_data), 32'(e.data));
            check("sb_ovf", 32'(out_ovf), 32'(e.ovf));
          end
        end
      end else begin
        check("idle_data_zero", 32'(out_data), 32'd0);
        check("idle_ovf_zero", 32'(out_ovf), 32'd0);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push_sample(input logic [7:0] d, input logic s);
    int budget;
    budget   = 0;
    in_data  = d;
    in_sub   = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic frame8(input logic [31:0] d, input logic [3:0] s, input logic [7:0] exp,
                        input logic eovf, input string name);
    for (int i = 0; i < 4; i++) begin
      d8 = d[8*i +: 8];
      s8 = s[i];
      v8 = 1'b1;
      @(posedge clk);
      #1;
    end
    v8 = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 32'(ov8), 32'd1);
    check({name, "_data"}, 32'(o8), 32'(exp));
    check({name, "_ovf"}, 32'(ovf8), 32'(eovf));
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, "_cleared"}, {30'd0, ov8, ovf8}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{d: 32'h01FD0A05, s: 4'b0000, exp: 16'h000D};
    vecs[1] = '{d: 32'h80808080, s: 4'b1111, exp: 16'h0200};
    vecs[2] = '{d: 32'h7F7F7F7F, s: 4'b0000, exp: 16'h01FC};
    vecs[3] = '{d: 32'hFFFF2010, s: 4'b1010, exp: 16'hFFF0};
    vecs[4] = '{d: 32'h80808080, s: 4'b0000, exp: 16'hFE00};
    vecs[5] = '{d: 32'h01010101, s: 4'b1111, exp: 16'hFFFC};

    rst_n = 1'b0;
    in_data = 8'h00; in_sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    d8 = 8'h00; s8 = 1'b0; v8 = 1'b0; ordy8 = 1'b1;
    d1 = 8'h00; s1 = 1'b0; v1 = 1'b0; ordy1 = 1'b1;
    #23;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven frames, back-to-back, Out_Ready = 1
    for (int v = 0; v < 6; v++) begin
      sbq.push_back('{data: vecs[v].exp, ovf: 1'b0});
      for (int i = 0; i < 4; i++) push_sample(vecs[v].d[8*i +: 8], vecs[v].s[i]);
      in_valid = 1'b0;
      @(negedge clk);
      check("latency_valid", 32'(out_valid), 32'd1);
      check("emit_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("post_handshake_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end

    // backpressure: result held, held upstream sample not consumed while in EMIT
    out_ready = 1'b0;
    sbq.push_back('{data: 16'h000D, ovf: 1'b0});
    for (int i = 0; i < 4; i++) push_sample(vecs[0].d[8*i +: 8], vecs[0].s[i]);
    in_data = 8'h55; in_sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'h000D);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    sbq.push_back('{data: 16'h0058, ovf: 1'b0});
    @(negedge clk);
    check("release_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_sample(8'h01, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // async reset mid-frame discards partial sum
    push_sample(8'h10, 1'b0);
    push_sample(8'h10, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{data: 16'h0004, ovf: 1'b0});
    for (int i = 0; i < 4; i++) push_sample(8'h01, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // async reset while a result is held discards it
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_sample(8'h7F, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("emitrst_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("emitrst_valid", 32'(out_valid), 32'd0);
    check("emitrst_data", 32'(out_data), 32'd0);
    check("emitrst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // ACC_W = 8 overflow handling
`ifdef SIGNED_ACC_SATURATE_EN
    frame8(32'h00006464, 4'b0000, 8'h7F, 1'b1, "acc8_pos_ovf");
    frame8(32'h01010101, 4'b0000, 8'h04, 1'b0, "acc8_clean");
    frame8(32'h00006464, 4'b0011, 8'h80, 1'b1, "acc8_neg_ovf");
    frame8(32'h009C6464, 4'b0000, 8'h1B, 1'b1, "acc8_after_clamp");
`else
    frame8(32'h00006464, 4'b0000, 8'hC8, 1'b1, "acc8_pos_ovf");
    frame8(32'h01010101, 4'b0000, 8'h04, 1'b0, "acc8_clean");
    frame8(32'h00006464, 4'b0011, 8'h38, 1'b1, "acc8_neg_ovf");
    frame8(32'h009C6464, 4'b0000, 8'h64, 1'b1, "acc8_after_wrap");
`endif

    // FRAME_LEN = 1: alternate-cycle acceptance with continuous upstream valid
    d1 = 8'hFF; s1 = 1'b0; v1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("fl1_valid", 32'(ov1), 32'(k % 2));
      check("fl1_in_ready", 32'(r1), 32'(1 - (k % 2)));
      check("fl1_data", 32'(o1), (k % 2 == 1) ? 32'h0000FFFF : 32'd0);
      check("fl1_ovf", 32'(ovf1), 32'd0);
    end
    v1 = 1'b0;

    for (int w = 0; w < 20 && sbq.size() != 0; w++) @(posedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/signed_frame_accumulator.md
SIGNED_FRAME_ACCUMULATOR -- requirements
Module: signed_frame_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input sample width (two's complement).
REQ-002 SHALL have parameter ACC_W, default 16, accumulator/result width; ACC_W >= DATA_W.
REQ-003 SHALL have parameter FRAME_LEN, default 4, accepted samples per emitted result; range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port In_Data  input  DATA_W  signed two's-complement sample from the upstream negation stage.
REQ-007 SHALL have port In_Sub  input  1  1 = subtract sample (add its two's complement), 0 = add; qualified by In_Valid.
REQ-008 SHALL have port In_Valid  input  1  upstream sample present.
REQ-009 SHALL have port In_Ready  output  1  block accepts a sample this cycle.
REQ-010 SHALL have port Out_Data  output  ACC_W  signed frame sum.
REQ-011 SHALL have port Out_Overflow  output  1  frame overflowed ACC_W; qualified by Out_Valid.
REQ-012 SHALL have port Out_Valid  output  1  result present.
REQ-013 SHALL have port Out_Ready  input  1  downstream accepts result.

Function
REQ-014 SHALL implement states IDLE (no samples in frame), ACCUM (1..FRAME_LEN-1 samples), EMIT (result held).
REQ-015 SHALL drive In_Ready = 1 in IDLE and ACCUM, 0 in EMIT; purely from state, no combinational path from Out_Ready.
REQ-016 SHALL accept a sample only on a cycle with In_Valid && In_Ready.
REQ-017 SHALL sign-extend In_Data to ACC_W+1 bits before negation, so subtracting the most-negative DATA_W value yields its exact positive magnitude.
REQ-018 SHALL add the extended (In_Sub=0) or negated extended (In_Sub=1) sample to the accumulator on the accepting edge.
REQ-019 SHALL count accepted samples; on the FRAME_LEN-th, move to EMIT at that edge with Out_Data = final sum and Out_Valid = 1 (one-cycle latency after last acceptance).
REQ-020 SHALL transition IDLE->ACCUM on first acceptance (IDLE->EMIT directly when FRAME_LEN = 1), ACCUM->EMIT on last acceptance.
REQ-021 SHALL hold Out_Data, Out_Overflow, Out_Valid stable in EMIT until Out_Valid && Out_Ready.
REQ-022 SHALL, on the output handshake edge, clear accumulator, count and overflow flag and enter IDLE; In_Ready rises the following cycle (no same-cycle bypass).
REQ-023 SHALL set a sticky overflow flag when any addition in the frame exceeds the signed ACC_W range; flag reported on Out_Overflow in EMIT.
REQ-024 SHALL hold Out_Data = 0 and Out_Overflow = 0 whenever Out_Valid = 0.
REQ-025 SHALL ignore In_Data/In_Sub when not accepted; In_Valid while in EMIT is neither lost nor consumed (upstream holds it).

Reset
REQ-026 SHALL, on rst_n low, immediately force state IDLE, accumulator 0, count 0, overflow flag 0, Out_Valid 0, Out_Data 0, Out_Overflow 0, In_Ready 1 (combinational from IDLE).
REQ-027 SHALL discard any partial frame or unaccepted result on reset; first frame after release starts from 0.
REQ-028 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL provide macro SIGNED_ACC_SATURATE_EN.
REQ-030 SHALL, with SIGNED_ACC_SATURATE_EN defined, clamp each overflowing sum to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and continue accumulating from the clamped value; overflow flag still set.
REQ-031 SHALL, without SIGNED_ACC_SATURATE_EN, wrap modulo 2^ACC_W; overflow flag still set.

Verification
REQ-032 Defaults, add 0x05, 0x0A, 0xFD, 0x01 back-to-back, Out_Ready=1 -> Out_Data 0x000D, Out_Overflow 0, Out_Valid one cycle after 4th acceptance.
REQ-033 Defaults, subtract 0x80 four times -> Out_Data 0x0200 (+512), Out_Overflow 0.
REQ-034 Defaults, complete frame, hold Out_Ready=0 for 5 cycles with In_Valid=1 -> Out_Data held, In_Ready 0, no sample consumed; Out_Ready=1 -> IDLE, next sample accepted following cycle.
REQ-035 ACC_W=8, add 0x64, 0x64, 0x00, 0x00 -> without macro Out_Data 0xC8, Out_Overflow 1; with SIGNED_ACC_SATURATE_EN Out_Data 0x7F, Out_Overflow 1.
REQ-036 Defaults, accept two samples, pulse rst_n low mid-cycle -> outputs 0 immediately; then add 0x01 x4 -> Out_Data 0x0004.
REQ-037 FRAME_LEN=1, add 0xFF with Out_Ready=1 -> Out_Data 0xFFFF one cycle later, alternate-cycle acceptance sustained.
